// File: rtl/uart_sfr_pkg.sv
// Shared constants for the 8051 serial port controller:
// SFR addresses, SCON bit positions and the flag bundle.
package uart_sfr_pkg;

    localparam logic [7:0] SFR_SBUF = 8'h99;
    localparam logic [7:0] SFR_SCON = 8'h98;

    localparam int TX_DEPTH_DEFAULT = 8;

    localparam int SCON_RI  = 0;
    localparam int SCON_TI  = 1;
    localparam int SCON_TXF = 2;
    localparam int SCON_OVR = 3;
    localparam int SCON_REN = 4;
    localparam int SCON_TXD = 5;

    typedef struct packed {
        logic txd;
        logic ren;
        logic ovr;
        logic ti;
        logic ri;
    } scon_flags_t;

    // Assemble the SCON read value; TXF comes live from the FIFO.
    function automatic logic [7:0] scon_pack(
        input scon_flags_t f,
        input logic        txf
    );
        logic [7:0] v;
        v           = '0;
        v[SCON_RI]  = f.ri;
        v[SCON_TI]  = f.ti;
        v[SCON_TXF] = txf;
        v[SCON_OVR] = f.ovr;
        v[SCON_REN] = f.ren;
        v[SCON_TXD] = f.txd;
        return v;
    endfunction

endpackage

// File: rtl/uart_sfr_ctrl_sync_fifo.sv
// First-word-fall-through FIFO with extra-MSB pointers;
// head is zero when empty, writes when full are refused.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_wr;
    logic             do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update; both wrap naturally modulo 2*DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array, no reset needed since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_sfr_ctrl.sv
// CPU-side SBUF/SCON controller: TX FIFO, RX capture,
// RI/TI/OVR/TXD flags and the serial interrupt.
module uart_sfr_ctrl
    import uart_sfr_pkg::*;
#(
    parameter int         DEPTH     = TX_DEPTH_DEFAULT,
    parameter logic [7:0] SBUF_ADDR = SFR_SBUF,
    parameter logic [7:0] SCON_ADDR = SFR_SCON
) (
    input  logic       clk_uart,
    input  logic       rst,
    input  logic [7:0] sfr_addr,
    input  logic       sfr_wr_en,
    input  logic [7:0] sfr_wr_data,
    input  logic       sfr_rd_en,
    output logic [7:0] sfr_rd_data,
    output logic [7:0] txd_to_uart,
    output logic       fifo_empty,
    input  logic       r_en,
    input  logic [7:0] r_data,
    input  logic       rxd_int,
    output logic       rxd_int_ack,
    output logic       uart_irq
);

    localparam int CW = $clog2(DEPTH) + 1;

    scon_flags_t flags;
    scon_flags_t flags_d;
    logic [7:0]  rx_buf;
    logic        rxd_prev;

    logic [CW-1:0] tx_count;
    logic          tx_full;
    logic          tx_empty;

    logic wr_sbuf;
    logic wr_scon;
    logic push_ok;
    logic pop_ok;
    logic ti_set;
    logic txd_set;
    logic rx_edge;
    logic ri_set;
    logic ovr_set;
    logic unused_wr_bits;

    assign wr_sbuf = sfr_wr_en && (sfr_addr == SBUF_ADDR);
    assign wr_scon = sfr_wr_en && (sfr_addr == SCON_ADDR);

    assign push_ok = wr_sbuf && !tx_full;
    assign pop_ok  = r_en && !tx_empty;
    assign ti_set  = pop_ok && (tx_count == CW'(1)) && !push_ok;
    assign txd_set = wr_sbuf && tx_full;

    assign rx_edge = rxd_int && !rxd_prev;
    assign ri_set  = rx_edge && flags.ren && !flags.ri;
    assign ovr_set = rx_edge && flags.ren && flags.ri;

    assign unused_wr_bits = ^{sfr_wr_data[7:6], sfr_wr_data[SCON_TXF]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_tx_fifo (
        .clk     (clk_uart),
        .rst     (rst),
        .wr_en   (wr_sbuf),
        .wr_data (sfr_wr_data),
        .rd_en   (r_en),
        .rd_data (txd_to_uart),
        .count   (tx_count),
        .full    (tx_full),
        .empty   (tx_empty)
    );

    assign fifo_empty  = tx_empty;
    assign rxd_int_ack = flags.ri;
    assign uart_irq    = flags.ri || flags.ti;

    // Next flag state: W0C clears from SCON writes, hardware sets win.
    always_comb begin
        flags_d = flags;
        if (wr_scon) begin
            flags_d.ri  = flags.ri  && sfr_wr_data[SCON_RI];
            flags_d.ti  = flags.ti  && sfr_wr_data[SCON_TI];
            flags_d.ovr = flags.ovr && sfr_wr_data[SCON_OVR];
            flags_d.txd = flags.txd && sfr_wr_data[SCON_TXD];
            flags_d.ren = sfr_wr_data[SCON_REN];
        end
        if (ri_set)  flags_d.ri  = 1'b1;
        if (ti_set)  flags_d.ti  = 1'b1;
        if (ovr_set) flags_d.ovr = 1'b1;
        if (txd_set) flags_d.txd = 1'b1;
    end

    // Flag, receive buffer and edge-detector registers.
    always_ff @(posedge clk_uart) begin
        if (rst) begin
            flags    <= '0;
            rx_buf   <= 8'h00;
            rxd_prev <= 1'b0;
        end else begin
            flags    <= flags_d;
            rxd_prev <= rxd_int;
            if (ri_set) rx_buf <= r_data;
        end
    end

    // Combinational SFR read mux; zero when not selected.
    always_comb begin
        sfr_rd_data = 8'h00;
        if (sfr_rd_en) begin
            if (sfr_addr == SCON_ADDR)
                sfr_rd_data = scon_pack(flags, tx_full);
            else if (sfr_addr == SBUF_ADDR)
                sfr_rd_data = rx_buf;
        end
    end

endmodule

// File: tb/tb_uart_sfr_ctrl.sv
// Directed bench for uart_sfr_ctrl with a queue-based
// reference model checked every cycle.
module tb_uart_sfr_ctrl;

    localparam int         DEPTH = 8;
    localparam logic [7:0] SBUF  = 8'h99;
    localparam logic [7:0] SCON  = 8'h98;

    logic       clk_uart = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sfr_addr = 8'h00;
    logic       sfr_wr_en = 1'b0;
    logic [7:0] sfr_wr_data = 8'h00;
    logic       sfr_rd_en = 1'b0;
    logic [7:0] sfr_rd_data;
    logic [7:0] txd_to_uart;
    logic       fifo_empty;
    logic       r_en = 1'b0;
    logic [7:0] r_data = 8'h00;
    logic       rxd_int = 1'b0;
    logic       rxd_int_ack;
    logic       uart_irq;

    int errs = 0;
    int checks = 0;

    uart_sfr_ctrl #(.DEPTH(DEPTH)) dut (
        .clk_uart    (clk_uart),
        .rst         (rst),
        .sfr_addr    (sfr_addr),
        .sfr_wr_en   (sfr_wr_en),
        .sfr_wr_data (sfr_wr_data),
        .sfr_rd_en   (sfr_rd_en),
        .sfr_rd_data (sfr_rd_data),
        .txd_to_uart (txd_to_uart),
        .fifo_empty  (fifo_empty),
        .r_en        (r_en),
        .r_data      (r_data),
        .rxd_int     (rxd_int),
        .rxd_int_ack (rxd_int_ack),
        .uart_irq    (uart_irq)
    );

    always #5 clk_uart = ~clk_uart;

    // Reference model state
    logic [7:0] q[$];
    bit         m_ri, m_ti, m_ovr, m_ren, m_txd, m_prev;
    logic [7:0] m_rx = 8'h00;

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_scon();
        return {2'b00, m_txd, m_ren, m_ovr, (q.size() == DEPTH), m_ti, m_ri};
    endfunction

    function automatic logic [7:0] m_rd();
        if (!sfr_rd_en) return 8'h00;
        if (sfr_addr == SCON) return m_scon();
        if (sfr_addr == SBUF) return m_rx;
        return 8'h00;
    endfunction

    // Model advance on each clock edge from the behavioural rules
    always @(posedge clk_uart) begin : model
        bit full, popped, pushed, wscon, wsbuf, edge_s, riset;
        if (rst) begin
            q.delete();
            {m_ri, m_ti, m_ovr, m_ren, m_txd, m_prev} = '0;
            m_rx = 8'h00;
        end else begin
            full   = (q.size() == DEPTH);
            wsbuf  = sfr_wr_en && sfr_addr == SBUF;
            wscon  = sfr_wr_en && sfr_addr == SCON;
            popped = r_en && q.size() != 0;
            pushed = wsbuf && !full;
            edge_s = rxd_int && !m_prev;
            riset  = edge_s && m_ren && !m_ri;
            if (wscon) begin
                if (!sfr_wr_data[0]) m_ri = 0;
                if (!sfr_wr_data[1]) m_ti = 0;
                if (!sfr_wr_data[3]) m_ovr = 0;
                if (!sfr_wr_data[5]) m_txd = 0;
            end
            if (popped && q.size() == 1 && !pushed) m_ti = 1;
            if (wsbuf && full) m_txd = 1;
            if (edge_s && m_ren && m_ri) m_ovr = 1;
            if (riset) begin
                m_ri = 1;
                m_rx = r_data;
            end
            if (wscon) m_ren = sfr_wr_data[4];
            if (popped) void'(q.pop_front());
            if (pushed) q.push_back(sfr_wr_data);
            m_prev = rxd_int;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk_uart) begin
        chk("cyc_empty", {7'd0, fifo_empty}, {7'd0, q.size() == 0});
        chk("cyc_txd", txd_to_uart, q.size() != 0 ? q[0] : 8'h00);
        chk("cyc_ack", {7'd0, rxd_int_ack}, {7'd0, m_ri});
        chk("cyc_irq", {7'd0, uart_irq}, {7'd0, m_ri || m_ti});
        chk("cyc_rd", sfr_rd_data, m_rd());
    end

    task automatic step();
        @(posedge clk_uart);
        #1;
    endtask

    task automatic sfr_wr(input logic [7:0] a, input logic [7:0] d);
        sfr_addr = a;
        sfr_wr_data = d;
        sfr_wr_en = 1'b1;
        step();
        sfr_wr_en = 1'b0;
    endtask

    task automatic sfr_rd(input logic [7:0] a, input logic [7:0] exp, input string name);
        sfr_addr = a;
        sfr_rd_en = 1'b1;
        #1;
        chk(name, sfr_rd_data, exp);
        step();
        sfr_rd_en = 1'b0;
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        sfr_rd(SCON, 8'h00, "scon_rst");
        sfr_rd(SBUF, 8'h00, "sbuf_rst");
        chk("empty_rst", {7'd0, fifo_empty}, 8'h01);
        chk("irq_rst", {7'd0, uart_irq}, 8'h00);

        sfr_wr(SBUF, 8'hA5);
        chk("push_lat", txd_to_uart, 8'hA5);
        sfr_wr(SBUF, 8'h3C);
        chk("head_hold", txd_to_uart, 8'hA5);
        r_en = 1'b1;
        step();
        chk("pop1", txd_to_uart, 8'h3C);
        step();
        r_en = 1'b0;
        chk("empty_pop2", {7'd0, fifo_empty}, 8'h01);
        chk("irq_ti", {7'd0, uart_irq}, 8'h01);
        sfr_rd(SCON, 8'h02, "scon_ti");
        sfr_wr(SCON, 8'h00);
        chk("ti_clr", {7'd0, uart_irq}, 8'h00);

        for (int i = 0; i <= DEPTH; i++) sfr_wr(SBUF, 8'h10 + 8'(i));
        sfr_rd(SCON, 8'h24, "scon_full");
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain", txd_to_uart, 8'h10 + 8'(i));
            r_en = 1'b1;
            step();
            r_en = 1'b0;
        end
        chk("drained", {7'd0, fifo_empty}, 8'h01);
        sfr_wr(SCON, 8'h00);

        sfr_wr(SCON, 8'h10);
        r_data = 8'h5A;
        rxd_int = 1'b1;
        step();
        chk("ri_ack", {7'd0, rxd_int_ack}, 8'h01);
        sfr_rd(SBUF, 8'h5A, "sbuf_rx");
        rxd_int = 1'b0;
        step();
        r_data = 8'h11;
        rxd_int = 1'b1;
        step();
        sfr_rd(SCON, 8'h19, "scon_ovr");
        sfr_rd(SBUF, 8'h5A, "sbuf_keep");

        sfr_wr(SCON, 8'h00);
        rxd_int = 1'b0;
        step();
        r_data = 8'h77;
        rxd_int = 1'b1;
        step();
        chk("ren0_ack", {7'd0, rxd_int_ack}, 8'h00);
        sfr_rd(SBUF, 8'h5A, "ren0_sbuf");

        rxd_int = 1'b0;
        sfr_wr(SCON, 8'h10);
        r_data = 8'hC3;
        rxd_int = 1'b1;
        sfr_wr(SCON, 8'h10);
        chk("set_wins", {7'd0, rxd_int_ack}, 8'h01);
        sfr_rd(SBUF, 8'hC3, "sbuf_c3");

        for (int i = 0; i < DEPTH; i++) sfr_wr(SBUF, 8'h20 + 8'(i));
        sfr_addr = SBUF;
        sfr_wr_data = 8'hEE;
        sfr_wr_en = 1'b1;
        r_en = 1'b1;
        step();
        sfr_wr_en = 1'b0;
        r_en = 1'b0;
        chk("full_pp", txd_to_uart, 8'h21);
        sfr_rd(SCON, 8'h31, "scon_full_pp");

        r_en = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        r_en = 1'b0;
        chk("rst_empty", {7'd0, fifo_empty}, 8'h01);
        chk("rst_irq", {7'd0, uart_irq}, 8'h00);
        sfr_rd(SCON, 8'h00, "scon_rst2");

        step();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
